// File: rtl/approx_add_err_sweep_pkg.sv
// Shared types and width helpers for the approximate-arithmetic
// characterization sweepers (adder now, subtractor/multiplier later).
package axc_char_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Sum of 2^(2w) errors, each below 2^(w+1).
  function automatic int sum_w(input int w);
    return 3 * w + 1;
  endfunction

  // Count of up to 2^(2w) pairs.
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/approx_add_err_sweep_if.sv
// Operand/result bus between the sweeper and the adder under test.
interface approx_add_err_sweep_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   approx_sum;

  modport master (
    output op_a,
    output op_b,
    input  approx_sum
  );

  modport slave (
    input  op_a,
    input  op_b,
    output approx_sum
  );

endinterface

// File: rtl/approx_add_err_sweep_abs_diff.sv
// Combinational unsigned |x - y|, shared by the sibling sweepers.
module abs_diff #(
  parameter int N = 9
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] d
);

  always_comb begin
    d = '0;
    if (x >= y) d = x - y;
    else        d = y - x;
  end

endmodule

// File: rtl/approx_add_err_sweep.sv
// Exhaustive error sweep of an approximate unsigned adder:
// accumulates sum of |err|, worst-case error with operands, error count.
module approx_add_err_sweep
  import axc_char_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SW = sum_w(WIDTH),
  localparam int CW = cnt_w(WIDTH),
  localparam int NW = 2 * WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  approx_add_err_sweep_if.master add,
  output logic                   busy,
  output logic                   done,
  output logic [SW-1:0]          sum_abs_err,
  output logic [WIDTH:0]         max_err,
  output logic [WIDTH-1:0]       max_err_a,
  output logic [WIDTH-1:0]       max_err_b,
  output logic [CW-1:0]          err_count
);

  state_t state;
  state_t state_n;

  logic [NW-1:0]  cnt;
  logic           load;
  logic           step;
  logic           last;
  logic [WIDTH:0] exact;
  logic [WIDTH:0] e;

  assign add.op_a = cnt[WIDTH-1:0];
  assign add.op_b = cnt[NW-1:WIDTH];

  assign last  = &cnt;
  assign exact = {1'b0, add.op_a} + {1'b0, add.op_b};

  abs_diff #(
    .N (WIDTH + 1)
  ) u_abs_diff (
    .x (add.approx_sum),
    .y (exact),
    .d (e)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = SWEEP;
        end
      end
      SWEEP: begin
        step = 1'b1;
        if (last) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == SWEEP);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      sum_abs_err <= '0;
      max_err     <= '0;
      max_err_a   <= '0;
      max_err_b   <= '0;
      err_count   <= '0;
    end else if (load) begin
      cnt         <= '0;
      sum_abs_err <= '0;
      max_err     <= '0;
      max_err_a   <= '0;
      max_err_b   <= '0;
      err_count   <= '0;
    end else if (step) begin
      // Counter parks on the last pair so DONE shows it.
      if (!last) cnt <= cnt + NW'(1);
      sum_abs_err <= sum_abs_err + SW'(e);
      err_count   <= err_count + CW'(e != '0);
      if (e > max_err) begin
        max_err   <= e;
        max_err_a <= add.op_a;
        max_err_b <= add.op_b;
      end
    end
  end

endmodule

// File: doc/approx_add_err_sweep.md
# approx_add_err_sweep

Exhaustive error-characterization engine for approximate unsigned adders in the circuit library. It drives every operand pair into a combinational approximate adder under test, reads the adder's sum back, and accumulates the metrics the library reports: sum of absolute errors (for MAE), worst-case error (WCE) with its operands, and error count (for EP). It sits around a single adder instance in the characterization harness, on the operand side and the result side of that adder's A/B/O interface.

## Interface

Parameters:
- `WIDTH`, default 8: operand width of the adder under test. The sum is `WIDTH+1` bits wide.

Ports:
- `clk`  in  1: the block's single clock. All registers update on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high. Clears all state and outputs.
- `start`  in  1: one-cycle request to begin a sweep. Honoured only in IDLE or DONE.
- `op_a`  out  WIDTH: operand A driven to the adder under test.
- `op_b`  out  WIDTH: operand B driven to the adder under test.
- `approx_sum`  in  WIDTH+1: combinational sum returned by the adder under test.
- `busy`  out  1: high while a sweep is in progress.
- `done`  out  1: high from sweep completion until the next accepted `start` or reset.
- `sum_abs_err`  out  3*WIDTH+1: Σ|approx − exact| over all pairs.
- `max_err`  out  WIDTH+1: largest |approx − exact| seen.
- `max_err_a`, `max_err_b`  out  WIDTH each: operands of the first pair that reached `max_err`.
- `err_count`  out  2*WIDTH+1: number of pairs with approx ≠ exact.

## Operation

- States are IDLE, SWEEP and DONE. Reset enters IDLE.
- Reset value is 0 for every output: `busy`, `done`, `op_a`, `op_b`, and all result registers.
- **IDLE or DONE, with `start`=1:** clear the pair counter and all accumulators, clear `done`, and go to SWEEP.
- **SWEEP:** pair counter `cnt` has 2*WIDTH bits. `op_a = cnt[WIDTH-1:0]` and `op_b = cnt[2*WIDTH-1:WIDTH]`, both driven directly from the registered counter. Each SWEEP cycle performs the following:
  - `exact = op_a + op_b` at `WIDTH+1` bits, which never overflows.
  - `e = |approx_sum − exact|`, computed at `WIDTH+1` bits unsigned.
  - `sum_abs_err += e`. The accumulator width is sized so that 2^(2W)·(2^(W+1)−1) cannot overflow.
  - `err_count += (e != 0)`.
  - If `e > max_err`, the block updates `max_err`, `max_err_a` and `max_err_b`. The comparison is strict, so the first occurrence in counter order wins.
  - `cnt++`. When `cnt` is all-ones, this is the last pair: the block accumulates it, then goes to DONE.
- **DONE:** `busy`=0, `done`=1, and results are held stable. `op_a`/`op_b` hold the last pair.
- `start` during SWEEP is ignored.
- Reset during SWEEP aborts immediately to IDLE with all outputs at 0. No partial results are retained.
- `approx_sum` is sampled only in SWEEP. Its value in other states is don't-care.

## Timing

- Edge N: `start` is sampled. At N+1, `busy`=1 and `cnt`=0, so pair (0,0) is on `op_a`/`op_b`.
- Exactly 2^(2*WIDTH) SWEEP cycles follow, one pair per cycle. The adder under test must settle within one clock period.
- Results are registered and updated on the same edge that consumes each pair.
- At the edge after the last pair is accumulated, `busy` goes 0 and `done` goes 1. Total latency from the `start` edge to `done`=1 is 2^(2*WIDTH)+1 cycles, which is 65537 for WIDTH=8.
- A back-to-back restart is allowed: `start` in the first DONE cycle begins a new sweep on the next cycle.

## Structure

- Shared package `axc_char_pkg` holds:
  - the state enum (IDLE, SWEEP, DONE);
  - width helper functions for the accumulators (`3*W+1`, `2*W+1`), reused by the future subtractor and multiplier sweepers.
- Sub-module `abs_diff` is a combinational `|x − y|` on `WIDTH+1` bits. It is instantiated once and reused by the sibling sweepers.

## Test plan

- **Exact adder, WIDTH=8** (`approx_sum = op_a + op_b`): `start` → after 65537 cycles, `done`=1, `sum_abs_err`=0, `max_err`=0, `max_err_a`=`max_err_b`=0, `err_count`=0.
- **Zero-output stub, WIDTH=8** (`approx_sum`=0): `sum_abs_err`=16711680, `max_err`=510, `max_err_a`=`max_err_b`=255, `err_count`=65535.
- **Off-by-one stub, WIDTH=8** (`approx_sum = op_a + op_b + 1`): `sum_abs_err`=65536, `max_err`=1, `max_err_a`=`max_err_b`=0 (first occurrence), `err_count`=65536.
- **WIDTH=2, zero-output stub:** `done` is asserted 17 cycles after `start`; `sum_abs_err`=48, `max_err`=6, `err_count`=15. The `op_a`/`op_b` sequence is checked against the counter order.
- **Reset mid-sweep:** assert `rst` asynchronously at cycle 1000 → all outputs are 0 immediately and the state is IDLE. A fresh `start` then reproduces the zero-output-stub results exactly.
- **`start` while busy:** pulse `start` at cycles 10 and 500 of a sweep → no restart; `done` arrives at cycle 65537 and the results are unchanged versus the single-start run.
